// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath.
// Moore decode of the state register; only PCLoad in BRANCH follows Zero directly.
module mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUFunc,
    output logic [1:0] PCSource,
    output logic       PCLoad,
    output logic       Trap,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_MEM_ADDR   = 4'd3,
        S_MEM_READ   = 4'd4,
        S_MEM_WAIT   = 4'd5,
        S_MEM_WB     = 4'd6,
        S_MEM_WRITE  = 4'd7,
        S_EXECUTE    = 4'd8,
        S_R_WB       = 4'd9,
        S_BRANCH     = 4'd10,
        S_JUMP       = 4'd11,
        S_ADDI_EXEC  = 4'd12,
        S_ADDI_WB    = 4'd13,
        S_TRAP       = 4'd14,
        S_UNUSED     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_XOR: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] sel;
        case (f)
            FN_ADD:  sel = ALU_ADD;
            FN_SUB:  sel = ALU_SUB;
            FN_AND:  sel = ALU_AND;
            FN_XOR:  sel = ALU_XOR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       is_sw_r;
    logic [2:0] rfunc_r;
    logic       ovf_trap_r;

    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_func_s;
    logic [1:0] pc_source_s;
    logic       pc_load_s;
    logic       trap_s;
    logic [3:0] state_dbg_s;

    // State register; opcode/funct facts are captured once, on the edge leaving DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_FETCH;
            is_sw_r    <= 1'b0;
            rfunc_r    <= ALU_ADD;
            ovf_trap_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == S_DECODE) begin
                is_sw_r    <= (Opcode == OP_SW);
                rfunc_r    <= funct_alu(Funct);
                ovf_trap_r <= (Funct == FN_ADD) || (Funct == FN_SUB);
            end else begin
                is_sw_r    <= is_sw_r;
                rfunc_r    <= rfunc_r;
                ovf_trap_r <= ovf_trap_r;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:      state_next_s = S_FETCH_WAIT;
            S_FETCH_WAIT: state_next_s = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
                    OP_RTYPE:     state_next_s = funct_legal(Funct) ? S_EXECUTE : S_TRAP;
                    OP_BEQ:       state_next_s = S_BRANCH;
                    OP_J:         state_next_s = S_JUMP;
                    OP_ADDI:      state_next_s = S_ADDI_EXEC;
                    default:      state_next_s = S_TRAP;
                endcase
            end
            S_MEM_ADDR:   state_next_s = is_sw_r ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:   state_next_s = S_MEM_WAIT;
            S_MEM_WAIT:   state_next_s = S_MEM_WB;
            S_MEM_WB:     state_next_s = S_FETCH;
            S_MEM_WRITE:  state_next_s = S_FETCH;
            // and/xor never trap, whatever the flag says
            S_EXECUTE:    state_next_s = (Overflow && ovf_trap_r) ? S_TRAP : S_R_WB;
            S_R_WB:       state_next_s = S_FETCH;
            S_BRANCH:     state_next_s = S_FETCH;
            S_JUMP:       state_next_s = S_FETCH;
            S_ADDI_EXEC:  state_next_s = Overflow ? S_TRAP : S_ADDI_WB;
            S_ADDI_WB:    state_next_s = S_FETCH;
            S_TRAP:       state_next_s = S_FETCH;
            default:      state_next_s = S_FETCH;
        endcase
    end

    // Output decode; reset forces everything (including ALUFunc and State) to zero.
    always_comb begin
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_func_s   = 3'b000;
        pc_source_s  = 2'b00;
        pc_load_s    = 1'b0;
        trap_s       = 1'b0;
        state_dbg_s  = 4'd0;
        if (reset) begin
            state_dbg_s = 4'd0;
        end else begin
            state_dbg_s = state_r;
            alu_func_s  = ALU_ADD;
            case (state_r)
                S_FETCH: begin
                    mem_read_s  = 1'b1;
                    alu_src_b_s = 2'b01;
                    pc_load_s   = 1'b1;
                end
                S_FETCH_WAIT: ir_write_s  = 1'b1;
                S_DECODE:     alu_src_b_s = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                end
                S_MEM_READ: begin
                    iord_s     = 1'b1;
                    mem_read_s = 1'b1;
                end
                // address held on ALUOut while MDR captures
                S_MEM_WAIT:   iord_s = 1'b1;
                S_MEM_WB: begin
                    mem_to_reg_s = 1'b1;
                    reg_write_s  = 1'b1;
                end
                S_MEM_WRITE: begin
                    iord_s      = 1'b1;
                    mem_write_s = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a_s = 1'b1;
                    alu_func_s  = rfunc_r;
                end
                S_R_WB: begin
                    reg_dst_s   = 1'b1;
                    reg_write_s = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_s = 1'b1;
                    alu_func_s  = ALU_SUB;
                    pc_source_s = 2'b01;
                    pc_load_s   = Zero;
                end
                S_JUMP: begin
                    pc_source_s = 2'b10;
                    pc_load_s   = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                end
                S_ADDI_WB:    reg_write_s = 1'b1;
                S_TRAP:       trap_s = 1'b1;
                default:      trap_s = 1'b1;
            endcase
        end
    end

    assign IorD     = iord_s;
    assign MemRead  = mem_read_s;
    assign MemWrite = mem_write_s;
    assign IRWrite  = ir_write_s;
    assign RegDst   = reg_dst_s;
    assign MemtoReg = mem_to_reg_s;
    assign RegWrite = reg_write_s;
    assign ALUSrcA  = alu_src_a_s;
    assign ALUSrcB  = alu_src_b_s;
    assign ALUFunc  = alu_func_s;
    assign PCSource = pc_source_s;
    assign PCLoad   = pc_load_s;
    assign Trap     = trap_s;
    assign State    = state_dbg_s;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each instruction pushes its expected
// per-cycle state and output vector, then the queue is drained against the DUT.
module tb_mc_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUFunc;
    logic [1:0] PCSource;
    logic       PCLoad, Trap;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [2:0]  exp_rf;
    logic [16:0] dut_outs;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .Overflow(Overflow), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUFunc(ALUFunc), .PCSource(PCSource),
        .PCLoad(PCLoad), .Trap(Trap), .State(State)
    );

    assign dut_outs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, ALUFunc, PCSource, PCLoad, Trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference output vector for one state, written from the state table.
    function automatic logic [16:0] ref_outs(input logic [3:0] s, input logic z, input logic [2:0] rf);
        logic iord, mrd, mwr, irw, rdst, m2r, rwr, srca, pcl, trp;
        logic [1:0] srcb, pcs;
        logic [2:0] fn;
        iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; rdst = 1'b0; m2r = 1'b0;
        rwr = 1'b0; srca = 1'b0; pcl = 1'b0; trp = 1'b0; srcb = 2'b00; pcs = 2'b00;
        fn = 3'b001;
        case (s)
            4'd0:  begin mrd = 1'b1; srcb = 2'b01; pcl = 1'b1; end
            4'd1:  irw = 1'b1;
            4'd2:  srcb = 2'b11;
            4'd3:  begin srca = 1'b1; srcb = 2'b10; end
            4'd4:  begin iord = 1'b1; mrd = 1'b1; end
            4'd5:  iord = 1'b1;
            4'd6:  begin m2r = 1'b1; rwr = 1'b1; end
            4'd7:  begin iord = 1'b1; mwr = 1'b1; end
            4'd8:  begin srca = 1'b1; fn = rf; end
            4'd9:  begin rdst = 1'b1; rwr = 1'b1; end
            4'd10: begin srca = 1'b1; fn = 3'b010; pcs = 2'b01; pcl = z; end
            4'd11: begin pcs = 2'b10; pcl = 1'b1; end
            4'd12: begin srca = 1'b1; srcb = 2'b10; end
            4'd13: rwr = 1'b1;
            default: trp = 1'b1;
        endcase
        return {iord, mrd, mwr, irw, rdst, m2r, rwr, srca, srcb, fn, pcs, pcl, trp};
    endfunction

    task automatic push(input logic [3:0] s);
        exp_t e;
        e.st   = s;
        e.outs = ref_outs(s, Zero, exp_rf);
        sb_q.push_back(e);
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        Overflow = ov;
    endtask

    // One expected entry per cycle; starts at a negedge in the first expected state.
    task automatic drain(input string name);
        exp_t e;
        int   n;
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            #1;
            e = sb_q.pop_front();
            checks++;
            if (State !== e.st) begin
                errors++;
                $display("FAIL %s state cyc%0d got %0d expected %0d", name, i, State, e.st);
            end
            checks++;
            if (dut_outs !== e.outs) begin
                errors++;
                $display("FAIL %s outs cyc%0d st%0d got %05h expected %05h", name, i, e.st, dut_outs, e.outs);
            end
            checks++;
            if ((MemRead && MemWrite) || (RegWrite && (MemWrite || IRWrite))) begin
                errors++;
                $display("FAIL %s exclusivity cyc%0d got rd%0b wr%0b rw%0b ir%0b expected no overlap",
                         name, i, MemRead, MemWrite, RegWrite, IRWrite);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(6'b000000, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_outs !== 17'd0 || State !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got st%0d outs %05h expected st0 outs 00000", i, State, dut_outs);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || dut_outs !== ref_outs(4'd0, 1'b0, 3'b001)) begin
            errors++;
            $display("FAIL reset_release got st%0d outs %05h expected st0 outs %05h",
                     State, dut_outs, ref_outs(4'd0, 1'b0, 3'b001));
        end
    endtask

    task automatic run_seq(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ov, input logic [2:0] rf, input logic [3:0] last);
        set_in(op, fn, z, ov);
        exp_rf = rf;
        push(4'd0); push(4'd1); push(4'd2);
        case (op)
            6'b100011: begin push(4'd3); push(4'd4); push(4'd5); push(4'd6); end
            6'b101011: begin push(4'd3); push(4'd7); end
            6'b000100: push(4'd10);
            6'b000010: push(4'd11);
            6'b001000: begin push(4'd12); push(last); end
            6'b000000: begin
                if (last == 4'd14 && rf == 3'b000) push(4'd14);
                else begin push(4'd8); push(last); end
            end
            default:   push(4'd14);
        endcase
        drain(name);
    endtask

    // Opcode/Funct change after DECODE must not affect the rest of the instruction.
    task automatic test_decode_latch();
        set_in(6'b101011, 6'h00, 1'b0, 1'b0);
        exp_rf = 3'b001;
        push(4'd0); push(4'd1); push(4'd2);
        drain("sw_latch_head");
        set_in(6'b100011, 6'h26, 1'b0, 1'b0);
        push(4'd3); push(4'd7);
        drain("sw_latch_tail");
        set_in(6'b000000, 6'h26, 1'b0, 1'b1);
        exp_rf = 3'b110;
        push(4'd0); push(4'd1); push(4'd2);
        drain("xor_latch_head");
        set_in(6'b111111, 6'h20, 1'b0, 1'b1);
        push(4'd8); push(4'd9);
        drain("xor_latch_tail");
    endtask

    task automatic test_reset_mid_sw();
        set_in(6'b101011, 6'h00, 1'b0, 1'b0);
        exp_rf = 3'b001;
        push(4'd0); push(4'd1); push(4'd2); push(4'd3);
        drain("mid_sw_head");
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || State !== 4'd0 || dut_outs !== 17'd0) begin
            errors++;
            $display("FAIL mid_sw_reset got st%0d memwrite %0b outs %05h expected st0 memwrite 0 outs 00000",
                     State, MemWrite, dut_outs);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || dut_outs !== ref_outs(4'd0, 1'b0, 3'b001)) begin
            errors++;
            $display("FAIL mid_sw_restart got st%0d outs %05h expected st0 outs %05h",
                     State, dut_outs, ref_outs(4'd0, 1'b0, 3'b001));
        end
    endtask

    task automatic test_back_to_back();
        run_seq("b2b_j",   6'b000010, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
        run_seq("b2b_add", 6'b000000, 6'h20, 1'b0, 1'b0, 3'b001, 4'd9);
        run_seq("b2b_lw",  6'b100011, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_rf = 3'b001;
        test_reset();
        run_seq("lw",        6'b100011, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
        run_seq("sw",        6'b101011, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
        run_seq("add",       6'b000000, 6'h20, 1'b0, 1'b0, 3'b001, 4'd9);
        run_seq("sub_ovf",   6'b000000, 6'h22, 1'b0, 1'b1, 3'b010, 4'd14);
        run_seq("sub_noovf", 6'b000000, 6'h22, 1'b0, 1'b0, 3'b010, 4'd9);
        run_seq("and_ovf",   6'b000000, 6'h24, 1'b0, 1'b1, 3'b011, 4'd9);
        run_seq("beq_taken", 6'b000100, 6'h00, 1'b1, 1'b0, 3'b001, 4'd0);
        run_seq("beq_not",   6'b000100, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
        run_seq("jump",      6'b000010, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
        run_seq("addi",      6'b001000, 6'h00, 1'b0, 1'b0, 3'b001, 4'd13);
        run_seq("addi_ovf",  6'b001000, 6'h00, 1'b0, 1'b1, 3'b001, 4'd14);
        run_seq("illegal_op", 6'b111111, 6'h00, 1'b0, 1'b0, 3'b001, 4'd0);
        run_seq("illegal_fn", 6'b000000, 6'h2A, 1'b0, 1'b0, 3'b000, 4'd14);
        test_decode_latch();
        test_reset_mid_sw();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
